fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage sitting directly upstream of the decoder. Owns the program counter, issues in-order reads to instruction memory, buffers returned 12-bit opcodes in a small FIFO, and presents them to the decoder over a valid/ready handshake. A redirect input (from branch/jump resolution) reloads the PC and discards all stale fetches.

## Interface
- ADDR_W, 8, PC / instruction-memory address width
- DEPTH, 2, instruction buffer depth and maximum in-flight requests (≥2)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  read request valid
- imem_req_addr  out  ADDR_W  read address (current PC)
- imem_req_ready  in  1  memory accepts request this cycle
- imem_rsp_valid  in  1  read data valid, in request order, ≥1 cycle after accept
- imem_rsp_data  in  12  returned opcode
- redirect_valid  in  1  load new PC, flush
- redirect_addr  in  ADDR_W  new PC
- out_valid  out  1  opcode available to decoder
- out_opcode  out  12  opcode to decoder (type/sub/reg_a/reg_b packed as [11:9]/[8:6]/[5:3]/[2:0])
- out_pc  out  ADDR_W  address the opcode was fetched from
- out_ready  in  1  decoder consumes this cycle

## Operation
- State: pc, in-flight address queue (DEPTH entries), in-flight count `outst`, discard count `drop`, output FIFO (opcode+pc, DEPTH entries).
- Request: imem_req_valid = !redirect_valid && (outst + fifo_count < DEPTH); imem_req_addr = pc. Credit counts all in-flight requests, including ones to be dropped, so a response always has a FIFO slot.
- Accept (req_valid & req_ready): push pc into address queue, outst += 1, pc = pc + 1 mod 2^ADDR_W (wraps 0xFF→0x00 at default).
- Response: outst -= 1, pop address queue. If drop > 0: drop -= 1, data discarded. Else push {imem_rsp_data, addr} into output FIFO.
- Output: out_valid = FIFO non-empty; out_opcode/out_pc = FIFO head; pop on out_valid & out_ready.
- Redirect (highest priority): pc = redirect_addr; output FIFO emptied (any same-cycle pop is moot); drop = outst − (1 if response this cycle else 0); address queue entries remain to match dropped responses; no request issued this cycle.
- Simultaneous response + accept: outst unchanged. Simultaneous push + pop on full FIFO: legal, count unchanged.
- Response with outst = 0 is a protocol error; assertion fires, state unchanged.

## Timing
- Reset values: pc = 0, outst = 0, drop = 0, FIFO empty; out_valid = 0, out_opcode = 0, out_pc = 0, imem_req_valid = 1 combinationally once rst_n high (addr 0x00). Reset asserted mid-operation clears everything immediately; responses arriving after reset release with outst = 0 are ignored.
- Response at cycle t → out_valid at t+1 (registered FIFO write).
- With 1-cycle memory latency and continuous out_ready: one opcode per cycle, steady state; first opcode out_valid 2 cycles after first accept.
- Redirect at cycle t → first request with redirect_addr at t+1; out_valid low at t+1.
- out_* hold stable while out_valid & !out_ready (no redirect).

## Structure
- Package cpu_pkg: OPCODE_W = 12, field position constants (TYPE_MSB/LSB etc.), shared with decoder and instruction definitions.
- Sub-module sync_fifo (params WIDTH, DEPTH; push/pop/flush, full/empty/count) instantiated twice: address queue (WIDTH = ADDR_W) and output buffer (WIDTH = 12 + ADDR_W).
- Counters sized $clog2(DEPTH+1).

## Test plan
- Reset then 1-cycle memory returning data = addr: out_pc 0,1,2,3 with out_opcode 0x000,0x001,0x002,0x003 on consecutive cycles, first out_valid 2 cycles after rst_n rises.
- out_ready held low 10 cycles: exactly DEPTH requests issued, then imem_req_valid = 0; releasing out_ready resumes with no lost or duplicated pc.
- Redirect to 0x40 with 2 requests outstanding: both responses dropped, next out_pc = 0x40, out_valid low the cycle after redirect.
- Redirect in same cycle as a response and an out pop: outst/drop correct, no stale opcode ever reaches out_*.
- pc at 0xFE, free-running: out_pc sequence 0xFE, 0xFF, 0x00.
- imem_req_ready randomly low, 3-cycle memory latency, random out_ready: opcode stream equals memory contents in address order (scoreboard).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode width and field layout used by fetch,
// decode and the instruction definitions.
package cpu_pkg;

    localparam int OPCODE_W  = 12;

    localparam int TYPE_MSB  = 11;
    localparam int TYPE_LSB  = 9;
    localparam int SUB_MSB   = 8;
    localparam int SUB_LSB   = 6;
    localparam int REG_A_MSB = 5;
    localparam int REG_A_LSB = 3;
    localparam int REG_B_MSB = 2;
    localparam int REG_B_LSB = 0;

    // Field view of an opcode, MSB first: type / sub / reg_a / reg_b
    typedef struct packed {
        logic [TYPE_MSB-TYPE_LSB:0]   op_type;
        logic [SUB_MSB-SUB_LSB:0]     op_sub;
        logic [REG_A_MSB-REG_A_LSB:0] reg_a;
        logic [REG_B_MSB-REG_B_LSB:0] reg_b;
    } opcode_t;

endpackage

// File: rtl/fetch_unit_chk.sv
// Invariant checks for fetch_unit bookkeeping and the memory response protocol.
module fetch_unit_chk #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input logic             clk,
    input logic             rst_n,
    input logic             imem_rsp_valid,
    input logic             accept,
    input logic             keep,
    input logic [CNT_W-1:0] outst,
    input logic [CNT_W-1:0] drop,
    input logic [CNT_W-1:0] aq_count,
    input logic             aq_empty,
    input logic             aq_full,
    input logic [CNT_W-1:0] ob_count,
    input logic             ob_full
);
    // A response with nothing in flight is a memory protocol error
    a_rsp_needs_outst: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (outst != '0));

    a_queue_tracks_outst: assert property (@(posedge clk) disable iff (!rst_n)
        aq_count == outst);

    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        drop <= outst);

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, outst} + {1'b0, ob_count}) <= (CNT_W+1)'(DEPTH));

    a_no_accept_when_queue_full: assert property (@(posedge clk) disable iff (!rst_n)
        aq_full |-> !accept);

    a_no_drop_when_idle: assert property (@(posedge clk) disable iff (!rst_n)
        aq_empty |-> (drop == '0));

    a_no_push_when_buffer_full: assert property (@(posedge clk) disable iff (!rst_n)
        ob_full |-> !keep);

endmodule

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush, usable at any depth >= 2.
// Head data is read straight from the storage registers.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == LAST_PTR) begin
            return '0;
        end else begin
            return ptr + PTR_W'(1'b1);
        end
    endfunction

    // Qualify requests: flush wins, pop needs data, push needs room (a same-cycle pop frees one)
    always_comb begin
        do_pop_s  = 1'b0;
        do_push_s = 1'b0;
        if (flush) begin
            do_pop_s  = 1'b0;
            do_push_s = 1'b0;
        end else begin
            do_pop_s  = pop && (count_r != '0);
            do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage, cleared on reset so the head reads as zero when nothing was ever written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = (count_r == FULL_CNT);
    assign empty = (count_r == '0);
    assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order reads, buffers returned
// opcodes with their fetch address, and hands them to the decoder.
// A redirect reloads the PC, empties the buffer and marks every in-flight
// read as stale so its response is discarded on arrival.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    output logic [ADDR_W-1:0]   imem_req_addr,
    input  logic                imem_req_ready,
    input  logic                imem_rsp_valid,
    input  logic [OPCODE_W-1:0] imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_addr,
    output logic                out_valid,
    output logic [OPCODE_W-1:0] out_opcode,
    output logic [ADDR_W-1:0]   out_pc,
    input  logic                out_ready
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = OPCODE_W + ADDR_W;

    logic [ADDR_W-1:0] pc_r;
    logic [CNT_W-1:0]  outst_r;
    logic [CNT_W-1:0]  drop_r;

    logic [CNT_W:0]    credit_used_s;
    logic              req_valid_s;
    logic              accept_s;
    logic              rsp_s;
    logic              keep_s;
    logic              pop_s;
    logic [CNT_W-1:0]  outst_after_rsp_s;

    logic [ADDR_W-1:0] aq_head_s;
    logic [CNT_W-1:0]  aq_count_s;
    logic              aq_full_s;
    logic              aq_empty_s;
    logic [OUT_W-1:0]  ob_wdata_s;
    logic [OUT_W-1:0]  ob_rdata_s;
    logic [CNT_W-1:0]  ob_count_s;
    logic              ob_full_s;
    logic              ob_empty_s;

    // Request credit and handshake decode; credit covers stale reads so every response has a slot
    always_comb begin
        credit_used_s     = {1'b0, outst_r} + {1'b0, ob_count_s};
        req_valid_s       = !redirect_valid && (credit_used_s < (CNT_W+1)'(DEPTH));
        accept_s          = req_valid_s && imem_req_ready;
        rsp_s             = imem_rsp_valid && (outst_r != '0);
        keep_s            = rsp_s && (drop_r == '0) && !redirect_valid;
        pop_s             = !ob_empty_s && out_ready;
        outst_after_rsp_s = rsp_s ? (outst_r - CNT_W'(1'b1)) : outst_r;
    end

    // Program counter: redirect wins, otherwise advance (with wrap) on each accepted request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= '0;
        end else if (redirect_valid) begin
            pc_r <= redirect_addr;
        end else if (accept_s) begin
            pc_r <= pc_r + ADDR_W'(1'b1);
        end
    end

    // In-flight count: +1 per accept, -1 per response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_r <= '0;
        end else begin
            outst_r <= outst_after_rsp_s + (accept_s ? CNT_W'(1'b1) : CNT_W'(1'b0));
        end
    end

    // Discard count: on redirect every read still in flight after this cycle is stale
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_r <= '0;
        end else if (redirect_valid) begin
            drop_r <= outst_after_rsp_s;
        end else if (rsp_s && (drop_r != '0)) begin
            drop_r <= drop_r - CNT_W'(1'b1);
        end
    end

    // Addresses of in-flight reads, consumed in order as responses arrive (stale ones included)
    sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (1'b0),
        .push  (accept_s),
        .pop   (rsp_s),
        .wdata (pc_r),
        .rdata (aq_head_s),
        .full  (aq_full_s),
        .empty (aq_empty_s),
        .count (aq_count_s)
    );

    assign ob_wdata_s = {imem_rsp_data, aq_head_s};

    // Opcode + pc buffer toward the decoder, emptied on redirect
    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_out_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (keep_s),
        .pop   (pop_s),
        .wdata (ob_wdata_s),
        .rdata (ob_rdata_s),
        .full  (ob_full_s),
        .empty (ob_empty_s),
        .count (ob_count_s)
    );

    fetch_unit_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_rsp_valid (imem_rsp_valid),
        .accept         (accept_s),
        .keep           (keep_s),
        .outst          (outst_r),
        .drop           (drop_r),
        .aq_count       (aq_count_s),
        .aq_empty       (aq_empty_s),
        .aq_full        (aq_full_s),
        .ob_count       (ob_count_s),
        .ob_full        (ob_full_s)
    );

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;
    assign out_valid      = !ob_empty_s;
    assign out_opcode     = ob_rdata_s[OUT_W-1:ADDR_W];
    assign out_pc         = ob_rdata_s[ADDR_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: an in-order memory model with programmable latency,
// directed scenarios, and a randomized run against an epoch-based reference.
module tb_fetch_unit;
    localparam int ADDR_W = 8;
    // Depth 4 lets a 1-cycle memory sustain one opcode per cycle
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_req_ready = 1'b1;
    logic              imem_rsp_valid = 1'b0;
    logic [11:0]       imem_rsp_data = 12'h000;
    logic              redirect_valid = 1'b0;
    logic [ADDR_W-1:0] redirect_addr = 8'h00;
    logic              out_valid;
    logic [11:0]       out_opcode;
    logic [ADDR_W-1:0] out_pc;
    logic              out_ready = 1'b0;

    fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .out_valid      (out_valid),
        .out_opcode     (out_opcode),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;
    int epoch = 0;
    int rsp_epoch = 0;

    logic [11:0] mem_data [256];
    logic [7:0]  pend_addr [$];
    int          pend_due [$];
    int          pend_epoch [$];

    // Observations of the cycle just completed
    logic        o_req_valid, o_accept, o_out_valid, o_pop, o_rsp, o_redirect, o_out_ready;
    logic [7:0]  o_req_addr, o_out_pc;
    logic [11:0] o_out_op;
    int          o_rsp_epoch;

    // One clock: sample at negedge, play memory, advance past posedge, drive next response
    task automatic tick();
        @(negedge clk);
        o_req_valid = imem_req_valid;
        o_req_addr  = imem_req_addr;
        o_out_valid = out_valid;
        o_out_pc    = out_pc;
        o_out_op    = out_opcode;
        o_out_ready = out_ready;
        o_accept    = imem_req_valid && imem_req_ready;
        o_pop       = out_valid && out_ready;
        o_rsp       = imem_rsp_valid;
        o_rsp_epoch = rsp_epoch;
        o_redirect  = redirect_valid;
        if (o_accept) begin
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat);
            pend_epoch.push_back(epoch);
        end
        if (o_redirect) epoch++;
        @(posedge clk);
        #1;
        cyc++;
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_data[pend_addr[0]];
            rsp_epoch      = pend_epoch[0];
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
            void'(pend_epoch.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 12'h000;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 8'h00;
        out_ready      = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 12'h000;
        pend_addr.delete();
        pend_due.delete();
        pend_epoch.delete();
        epoch++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_pc !== 8'h00) begin bad++; $display("FAIL reset_out_pc got=%h exp=00", out_pc); end
        total++; if (out_opcode !== 12'h000) begin bad++; $display("FAIL reset_out_opcode got=%h exp=000", out_opcode); end
        do_reset();
        total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL reset_req_valid got=%b exp=1", imem_req_valid); end
        total++; if (imem_req_addr !== 8'h00) begin bad++; $display("FAIL reset_req_addr got=%h exp=00", imem_req_addr); end
        // Fill the buffer, then assert reset mid-cycle: outputs clear immediately
        lat = 1;
        repeat (6) tick();
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_pc !== 8'h00 || out_opcode !== 12'h000) begin
            bad++; $display("FAIL midreset_out_data got=%h/%h exp=00/000", out_pc, out_opcode);
        end
    endtask

    task automatic test_stream();
        do_reset();
        lat = 1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (c < 2) begin
                total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL stream_early_valid c=%0d got=%b exp=0", c, o_out_valid); end
            end else if (c < 6) begin
                total++;
                if (o_out_valid !== 1'b1 || o_out_pc !== 8'(c - 2) || o_out_op !== 12'(c - 2)) begin
                    bad++; $display("FAIL stream_out c=%0d got=%b/%h/%h exp=1/%h/%h", c, o_out_valid, o_out_pc, o_out_op, 8'(c - 2), 12'(c - 2));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n_acc;
        int exp_pc;
        do_reset();
        lat = 1;
        n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (o_accept) begin
                total++; if (o_req_addr !== 8'(n_acc)) begin bad++; $display("FAIL bp_req_addr got=%h exp=%h", o_req_addr, 8'(n_acc)); end
                n_acc++;
            end
        end
        total++; if (n_acc != DEPTH) begin bad++; $display("FAIL bp_req_count got=%0d exp=%0d", n_acc, DEPTH); end
        total++; if (o_req_valid !== 1'b0) begin bad++; $display("FAIL bp_req_valid got=%b exp=0", o_req_valid); end
        total++; if (o_out_valid !== 1'b1 || o_out_pc !== 8'h00) begin bad++; $display("FAIL bp_hold got=%b/%h exp=1/00", o_out_valid, o_out_pc); end
        out_ready = 1'b1;
        exp_pc = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (o_pop) begin
                total++;
                if (o_out_pc !== 8'(exp_pc) || o_out_op !== mem_data[exp_pc]) begin
                    bad++; $display("FAIL bp_resume got=%h/%h exp=%h/%h", o_out_pc, o_out_op, 8'(exp_pc), mem_data[exp_pc]);
                end
                exp_pc++;
            end
        end
        total++; if (exp_pc < 10) begin bad++; $display("FAIL bp_resume_count got=%0d exp>=10", exp_pc); end
    endtask

    // Collect pops after a redirect and require target, target+1, ... with at least min_n of them
    task automatic redirect_tail(input string tag, input logic [7:0] target, input int min_n);
        logic [7:0] exp_pc;
        int         n;
        exp_pc = target;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (o_pop) begin
                total++;
                if (o_out_pc !== exp_pc || o_out_op !== mem_data[exp_pc]) begin
                    bad++; $display("FAIL %s_stream got=%h/%h exp=%h/%h", tag, o_out_pc, o_out_op, exp_pc, mem_data[exp_pc]);
                end
                exp_pc = exp_pc + 8'h01;
                n++;
            end
        end
        total++; if (n < min_n) begin bad++; $display("FAIL %s_count got=%0d exp>=%0d", tag, n, min_n); end
    endtask

    task automatic test_redirect();
        bit found;
        do_reset();
        lat = 3;
        out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (cyc >= 2 && pend_addr.size() == 2) begin found = 1'b1; break; end
            tick();
        end
        total++; if (!found) begin bad++; $display("FAIL redir_setup got=timeout exp=2 outstanding"); end
        redirect_valid = 1'b1;
        redirect_addr  = 8'h40;
        tick();
        redirect_valid = 1'b0;
        tick();
        total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL redir_valid_after got=%b exp=0", o_out_valid); end
        total++; if (o_req_valid !== 1'b1 || o_req_addr !== 8'h40) begin
            bad++; $display("FAIL redir_req got=%b/%h exp=1/40", o_req_valid, o_req_addr);
        end
        redirect_tail("redir", 8'h40, 3);
    endtask

    task automatic test_redirect_collide();
        bit found;
        do_reset();
        lat = 1;
        out_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (cyc >= 4 && imem_rsp_valid && out_valid) begin found = 1'b1; break; end
            tick();
        end
        total++; if (!found) begin bad++; $display("FAIL collide_setup got=timeout exp=rsp+pop"); end
        redirect_valid = 1'b1;
        redirect_addr  = 8'h80;
        tick();
        redirect_valid = 1'b0;
        total++; if (o_rsp !== 1'b1 || o_pop !== 1'b1) begin bad++; $display("FAIL collide_cond got=%b/%b exp=1/1", o_rsp, o_pop); end
        tick();
        total++; if (o_out_valid !== 1'b0) begin bad++; $display("FAIL collide_valid_after got=%b exp=0", o_out_valid); end
        total++; if (o_req_valid !== 1'b1 || o_req_addr !== 8'h80) begin
            bad++; $display("FAIL collide_req got=%b/%h exp=1/80", o_req_valid, o_req_addr);
        end
        redirect_tail("collide", 8'h80, 4);
    endtask

    task automatic test_wrap();
        do_reset();
        lat = 1;
        out_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 8'hFE;
        tick();
        redirect_valid = 1'b0;
        redirect_tail("wrap", 8'hFE, 4);
    endtask

    // Reference: accepted pcs of the current epoch form the expected output order;
    // responses tagged with an older epoch never reach the buffer
    task automatic test_random();
        logic [7:0]  m_pc;
        logic [7:0]  m_exp [$];
        int          m_buf;
        bit          exp_rv;
        bit          prev_hold;
        logic [7:0]  prev_pc;
        logic [11:0] prev_op;
        for (int i = 0; i < 256; i++) mem_data[i] = 12'($urandom);
        do_reset();
        lat = 3;
        m_pc = 8'h00;
        m_buf = 0;
        prev_hold = 1'b0;
        prev_pc = 8'h00;
        prev_op = 12'h000;
        for (int c = 0; c < 1500; c++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            out_ready      = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 39) == 0);
            redirect_addr  = 8'($urandom);
            exp_rv = !redirect_valid && ((pend_addr.size() + (imem_rsp_valid ? 1 : 0) + m_buf) < DEPTH);
            tick();
            total++; if (o_req_valid !== exp_rv) begin bad++; $display("FAIL rnd_req_valid c=%0d got=%b exp=%b", c, o_req_valid, exp_rv); end
            if (exp_rv) begin
                total++; if (o_req_addr !== m_pc) begin bad++; $display("FAIL rnd_req_addr c=%0d got=%h exp=%h", c, o_req_addr, m_pc); end
            end
            total++; if (o_out_valid !== (m_buf > 0)) begin bad++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, o_out_valid, (m_buf > 0)); end
            if (m_buf > 0 && m_exp.size() > 0) begin
                total++;
                if (o_out_pc !== m_exp[0] || o_out_op !== mem_data[m_exp[0]]) begin
                    bad++; $display("FAIL rnd_out_data c=%0d got=%h/%h exp=%h/%h", c, o_out_pc, o_out_op, m_exp[0], mem_data[m_exp[0]]);
                end
            end
            if (prev_hold) begin
                total++;
                if (o_out_valid !== 1'b1 || o_out_pc !== prev_pc || o_out_op !== prev_op) begin
                    bad++; $display("FAIL rnd_hold c=%0d got=%b/%h/%h exp=1/%h/%h", c, o_out_valid, o_out_pc, o_out_op, prev_pc, prev_op);
                end
            end
            prev_hold = o_out_valid && !o_out_ready && !o_redirect;
            prev_pc   = o_out_pc;
            prev_op   = o_out_op;
            if (o_redirect) begin
                m_pc = redirect_addr;
                m_exp.delete();
                m_buf = 0;
            end else begin
                if (o_accept) begin
                    m_exp.push_back(m_pc);
                    m_pc = m_pc + 8'h01;
                end
                if (o_rsp && o_rsp_epoch == epoch) m_buf++;
                if (o_pop) begin
                    if (m_exp.size() > 0) void'(m_exp.pop_front());
                    if (m_buf > 0) m_buf--;
                end
            end
        end
        redirect_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_data[i] = 12'(i);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_collide();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
